// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter: shares one registered physical memory port between fetch & data
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        imem_read,
  output logic [31:0] instr,
  output logic        imem_resp,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [3:0]  pmem_byte_enable,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IFETCH  = 3'd1,
    DACCESS = 3'd2,
    IDONE   = 3'd3,
    DDONE   = 3'd4
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t      state_q;
  logic        last_grant_q;
  logic [31:0] instr_q;
  logic        imem_resp_q;
  logic [31:0] mem_rdata_q;
  logic        mem_resp_q;
  logic [31:0] pmem_address_q;
  logic [31:0] pmem_wdata_q;
  logic        pmem_read_q;
  logic        pmem_write_q;
  logic [3:0]  pmem_be_q;

  logic w_dreq;
  logic w_grant_data;

  assign w_dreq = mem_read | mem_write;
  // Data wins when alone, when priority is fixed, or when fetch was served last.
  assign w_grant_data = w_dreq & (~imem_read | ~RR_EN | (last_grant_q == GRANT_I));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_grant_q   <= GRANT_I;
      instr_q        <= '0;
      imem_resp_q    <= 1'b0;
      mem_rdata_q    <= '0;
      mem_resp_q     <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_be_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_grant_data) begin
            pmem_address_q <= mem_address;
            pmem_wdata_q   <= mem_wdata;
            pmem_be_q      <= mem_byte_enable;
            // A combined read+write request is carried out as the write.
            pmem_write_q   <= mem_write;
            pmem_read_q    <= ~mem_write;
            state_q        <= DACCESS;
          end else if (imem_read) begin
            pmem_address_q <= pc;
            pmem_wdata_q   <= '0;
            pmem_be_q      <= 4'hF;
            pmem_write_q   <= 1'b0;
            pmem_read_q    <= 1'b1;
            state_q        <= IFETCH;
          end
        end
        IFETCH: begin
          if (pmem_resp) begin
            instr_q      <= pmem_rdata;
            imem_resp_q  <= 1'b1;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            last_grant_q <= GRANT_I;
            state_q      <= IDONE;
          end
        end
        DACCESS: begin
          if (pmem_resp) begin
            mem_rdata_q  <= pmem_rdata;
            mem_resp_q   <= 1'b1;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            last_grant_q <= GRANT_D;
            state_q      <= DDONE;
          end
        end
        IDONE: begin
          imem_resp_q <= 1'b0;
          state_q     <= IDLE;
        end
        DDONE: begin
          mem_resp_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr            = instr_q;
  assign imem_resp        = imem_resp_q;
  assign mem_rdata        = mem_rdata_q;
  assign mem_resp         = mem_resp_q;
  assign pmem_address     = pmem_address_q;
  assign pmem_wdata       = pmem_wdata_q;
  assign pmem_read        = pmem_read_q;
  assign pmem_write       = pmem_write_q;
  assign pmem_byte_enable = pmem_be_q;

endmodule
`default_nettype wire
